sal_cmd_sched: RTL and testbench

- Channel-level DRAM command scheduler, parametrised in bank count.
- Collects per-bank ACT/RD/WR/PRE/REF requests from NUM_BANKS bank controllers and enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW).
- Grants at most one command per cycle and drives a registered command toward the DFI/PHY side.
- Sits between the bank-controller array and the DFI command encoder; its request/grant semantics match the per-bank scheduler interface, one bundle per bank.

---
 rtl/sal_sched_pkg.sv | 26 ++
 rtl/sal_rr_arbiter.sv | 34 +++
 rtl/sal_cmd_sched.sv | 199 +++++++++++++++++++
 tb/tb_sal_cmd_sched.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_sched_pkg.sv
// Shared types for the SAL channel command scheduler: command encodings and
// the fixed priority order in which command classes compete for a cycle.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_type_e;

  typedef enum logic [1:0] {
    CLS_REF = 2'd0,
    CLS_CAS = 2'd1,
    CLS_ACT = 2'd2,
    CLS_PRE = 2'd3
  } cmd_class_e;

  localparam int NUM_CLASSES = 4;

  // Highest priority first; the scheduler walks this list and stops at the first class with work.
  localparam cmd_class_e CLASS_ORDER [NUM_CLASSES] = '{CLS_REF, CLS_CAS, CLS_ACT, CLS_PRE};

endpackage

// File: rtl/sal_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping from N-1 to 0, and reports the pointer to use next.
module sal_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic [IW-1:0] next_ptr,
  output logic          gnt_valid
);

  always_comb begin
    int idx;
    gnt       = '0;
    gnt_idx   = '0;
    next_ptr  = ptr;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = IW'(idx);
        next_ptr  = (idx == N - 1) ? '0 : IW'(idx + 1);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// Channel-level DRAM command scheduler: picks one bank command per cycle under
// tRRD/tCCD/tWTR/tRTW spacing. Define SAL_SCHED_FAW_EN to add the tFAW window.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int BA_W      = $clog2(NUM_BANKS),
  parameter int RA_W      = 16,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int T_W       = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BANKS-1:0]       act_req,
  input  logic [NUM_BANKS-1:0]       rd_req,
  input  logic [NUM_BANKS-1:0]       wr_req,
  input  logic [NUM_BANKS-1:0]       pre_req,
  input  logic [NUM_BANKS-1:0]       ref_req,
  input  logic [NUM_BANKS*RA_W-1:0]  ra_in,
  input  logic [NUM_BANKS*CA_W-1:0]  ca_in,
  input  logic [NUM_BANKS*ID_W-1:0]  id_in,
  input  logic [NUM_BANKS*LEN_W-1:0] len_in,
  output logic [NUM_BANKS-1:0]       act_gnt,
  output logic [NUM_BANKS-1:0]       rd_gnt,
  output logic [NUM_BANKS-1:0]       wr_gnt,
  output logic [NUM_BANKS-1:0]       pre_gnt,
  output logic [NUM_BANKS-1:0]       ref_gnt,
  input  logic [T_W-1:0]             t_rrd_m1,
  input  logic [T_W-1:0]             t_ccd_m1,
  input  logic [T_W-1:0]             t_wtr_m1,
  input  logic [T_W-1:0]             t_rtw_m1,
  input  logic [T_W+1:0]             t_faw_m1,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_type,
  output logic [BA_W-1:0]            cmd_ba,
  output logic [RA_W-1:0]            cmd_ra,
  output logic [CA_W-1:0]            cmd_ca,
  output logic [ID_W-1:0]            cmd_id,
  output logic [LEN_W-1:0]           cmd_len
);

  logic [T_W-1:0]       rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic [BA_W-1:0]      rr_ptr, arb_idx, arb_next;
  logic [NUM_BANKS-1:0] rd_m, wr_m, act_m, pre_m, rd_el, wr_el;
  logic [NUM_BANKS-1:0] arb_req, arb_gnt;
  logic [NUM_BANKS-1:0] elig [NUM_CLASSES];
  logic                 rd_ok, wr_ok, act_ok, faw_ok;
  logic                 arb_valid, cls_found;
  cmd_class_e           win_cls;
  cmd_type_e            gnt_type;
  logic                 act_fire, rd_fire, wr_fire;

  // A bank competes only with its highest-class request; RD wins over WR inside one bank.
  assign rd_m  = rd_req & ~ref_req;
  assign wr_m  = wr_req & ~ref_req & ~rd_req;
  assign act_m = act_req & ~(ref_req | rd_req | wr_req);
  assign pre_m = pre_req & ~(ref_req | rd_req | wr_req | act_req);

  assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);
  assign act_ok = (rrd_cnt == '0) && faw_ok;
  assign rd_el  = rd_m & {NUM_BANKS{rd_ok}};
  assign wr_el  = wr_m & {NUM_BANKS{wr_ok}};

  always_comb begin
    elig[CLS_REF] = ref_req;
    elig[CLS_CAS] = rd_el | wr_el;
    elig[CLS_ACT] = act_m & {NUM_BANKS{act_ok}};
    elig[CLS_PRE] = pre_m;
  end

  always_comb begin
    win_cls   = CLS_PRE;
    cls_found = 1'b0;
    arb_req   = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (!cls_found && (elig[CLASS_ORDER[i]] != '0)) begin
        win_cls   = CLASS_ORDER[i];
        cls_found = 1'b1;
        arb_req   = elig[CLASS_ORDER[i]];
      end
    end
    if (!rst_n) arb_req = '0;
  end

  sal_rr_arbiter #(
    .N  (NUM_BANKS),
    .IW (BA_W)
  ) u_arb (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .next_ptr  (arb_next),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    act_gnt  = '0;
    rd_gnt   = '0;
    wr_gnt   = '0;
    pre_gnt  = '0;
    ref_gnt  = '0;
    gnt_type = CMD_NOP;
    if (arb_valid) begin
      case (win_cls)
        CLS_REF: begin
          ref_gnt  = arb_gnt;
          gnt_type = CMD_REF;
        end
        CLS_CAS: begin
          rd_gnt   = arb_gnt & rd_el;
          wr_gnt   = arb_gnt & wr_el;
          gnt_type = rd_el[arb_idx] ? CMD_RD : CMD_WR;
        end
        CLS_ACT: begin
          act_gnt  = arb_gnt;
          gnt_type = CMD_ACT;
        end
        default: begin
          pre_gnt  = arb_gnt;
          gnt_type = CMD_PRE;
        end
      endcase
    end
  end

  assign act_fire = (gnt_type == CMD_ACT);
  assign rd_fire  = (gnt_type == CMD_RD);
  assign wr_fire  = (gnt_type == CMD_WR);

  // Spacing counters load in the grant cycle and count down to zero, which re-enables the class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      wtr_cnt <= '0;
      rtw_cnt <= '0;
      rr_ptr  <= '0;
    end else begin
      rrd_cnt <= act_fire ? t_rrd_m1 : ((rrd_cnt != '0) ? rrd_cnt - 1'b1 : '0);
      ccd_cnt <= (rd_fire || wr_fire) ? t_ccd_m1 : ((ccd_cnt != '0) ? ccd_cnt - 1'b1 : '0);
      wtr_cnt <= wr_fire ? t_wtr_m1 : ((wtr_cnt != '0) ? wtr_cnt - 1'b1 : '0);
      rtw_cnt <= rd_fire ? t_rtw_m1 : ((rtw_cnt != '0) ? rtw_cnt - 1'b1 : '0);
      if (arb_valid) rr_ptr <= arb_next;
    end
  end

`ifdef SAL_SCHED_FAW_EN
  logic [T_W+1:0] faw_cnt [4];

  // Slots stay in age order, so the youngest ACT enters slot 0 and the oldest drops off slot 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) faw_cnt[i] <= '0;
    end else if (act_fire) begin
      faw_cnt[0] <= t_faw_m1;
      for (int i = 1; i < 4; i++)
        faw_cnt[i] <= (faw_cnt[i-1] != '0) ? faw_cnt[i-1] - 1'b1 : '0;
    end else begin
      for (int i = 0; i < 4; i++)
        faw_cnt[i] <= (faw_cnt[i] != '0) ? faw_cnt[i] - 1'b1 : '0;
    end
  end

  assign faw_ok = (faw_cnt[0] == '0) || (faw_cnt[1] == '0) ||
                  (faw_cnt[2] == '0) || (faw_cnt[3] == '0);
`else
  logic unused_faw;
  assign unused_faw = ^t_faw_m1;
  assign faw_ok     = 1'b1;
`endif

  // Command register toward the PHY; address fields hold when the slot is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_ba    <= '0;
      cmd_ra    <= '0;
      cmd_ca    <= '0;
      cmd_id    <= '0;
      cmd_len   <= '0;
    end else begin
      cmd_valid <= arb_valid;
      cmd_type  <= gnt_type;
      if (arb_valid) begin
        cmd_ba  <= arb_idx;
        cmd_ra  <= ra_in[arb_idx*RA_W +: RA_W];
        cmd_ca  <= ca_in[arb_idx*CA_W +: CA_W];
        cmd_id  <= id_in[arb_idx*ID_W +: ID_W];
        cmd_len <= len_in[arb_idx*LEN_W +: LEN_W];
      end
    end
  end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Self-checking bench for sal_cmd_sched: per-scenario grant checks plus a
// scoreboard of expected PHY commands compared one cycle after each grant.
module tb_sal_cmd_sched;

  localparam int N = 16;

  localparam logic [2:0] T_NOP = 3'd0;
  localparam logic [2:0] T_ACT = 3'd1;
  localparam logic [2:0] T_RD  = 3'd2;
  localparam logic [2:0] T_WR  = 3'd3;
  localparam logic [2:0] T_PRE = 3'd4;
  localparam logic [2:0] T_REF = 3'd5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   act_req, rd_req, wr_req, pre_req, ref_req;
  logic [N*16-1:0] ra_in;
  logic [N*10-1:0] ca_in;
  logic [N*4-1:0] id_in;
  logic [N*4-1:0] len_in;
  logic [N-1:0]   act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [4:0]     t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
  logic [6:0]     t_faw_m1;
  logic           cmd_valid;
  logic [2:0]     cmd_type;
  logic [3:0]     cmd_ba;
  logic [15:0]    cmd_ra;
  logic [9:0]     cmd_ca;
  logic [3:0]     cmd_id;
  logic [3:0]     cmd_len;
  logic [5*N-1:0] gnt_all;

  typedef struct {
    int         due;
    logic [2:0] t;
    int         b;
  } exp_cmd_t;

  exp_cmd_t sb[$];
  int       cyc    = 0;
  int       checks = 0;
  int       passes = 0;
  logic [3:0]  last_ba;
  logic [15:0] last_ra;
  logic [9:0]  last_ca;
  logic [3:0]  last_id, last_len;

  sal_cmd_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .act_req   (act_req),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .pre_req   (pre_req),
    .ref_req   (ref_req),
    .ra_in     (ra_in),
    .ca_in     (ca_in),
    .id_in     (id_in),
    .len_in    (len_in),
    .act_gnt   (act_gnt),
    .rd_gnt    (rd_gnt),
    .wr_gnt    (wr_gnt),
    .pre_gnt   (pre_gnt),
    .ref_gnt   (ref_gnt),
    .t_rrd_m1  (t_rrd_m1),
    .t_ccd_m1  (t_ccd_m1),
    .t_wtr_m1  (t_wtr_m1),
    .t_rtw_m1  (t_rtw_m1),
    .t_faw_m1  (t_faw_m1),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_ba    (cmd_ba),
    .cmd_ra    (cmd_ra),
    .cmd_ca    (cmd_ca),
    .cmd_id    (cmd_id),
    .cmd_len   (cmd_len)
  );

  assign gnt_all = {ref_gnt, pre_gnt, wr_gnt, rd_gnt, act_gnt};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ra_of(input int b);
    return 16'h1A28 + 16'(b);
  endfunction
  function automatic logic [9:0] ca_of(input int b);
    return 10'h200 + 10'(b * 5);
  endfunction
  function automatic logic [3:0] id_of(input int b);
    return 4'(b) ^ 4'h5;
  endfunction
  function automatic logic [3:0] len_of(input int b);
    return 4'(15 - b);
  endfunction

  function automatic logic [5*N-1:0] gvec(input logic [2:0] t, input int b);
    logic [5*N-1:0] v;
    v = '0;
    case (t)
      T_ACT:   v[b]       = 1'b1;
      T_RD:    v[N+b]     = 1'b1;
      T_WR:    v[2*N+b]   = 1'b1;
      T_PRE:   v[3*N+b]   = 1'b1;
      T_REF:   v[4*N+b]   = 1'b1;
      default: v          = '0;
    endcase
    return v;
  endfunction

  task automatic push_cmd(input logic [2:0] t, input int b);
    exp_cmd_t e;
    e.due = cyc + 1;
    e.t   = t;
    e.b   = b;
    sb.push_back(e);
  endtask

  task automatic drop_req(input logic [2:0] t, input int b);
    case (t)
      T_ACT:   act_req[b] = 1'b0;
      T_RD:    rd_req[b]  = 1'b0;
      T_WR:    wr_req[b]  = 1'b0;
      T_PRE:   pre_req[b] = 1'b0;
      T_REF:   ref_req[b] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic do_reset(input int rrd, input int ccd, input int wtr, input int rtw, input int faw);
    @(posedge clk); #1;
    rst_n = 1'b0;
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    t_rrd_m1 = 5'(rrd); t_ccd_m1 = 5'(ccd); t_wtr_m1 = 5'(wtr); t_rtw_m1 = 5'(rtw);
    t_faw_m1 = 7'(faw);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: every negedge either retires the command due now or expects an idle NOP slot.
  always @(negedge clk) begin
    exp_cmd_t e;
    if (!rst_n) begin
      last_ba = '0; last_ra = '0; last_ca = '0; last_id = '0; last_len = '0;
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_type !== e.t || cmd_ba !== 4'(e.b) || cmd_ra !== ra_of(e.b) ||
          cmd_ca !== ca_of(e.b) || cmd_id !== id_of(e.b) || cmd_len !== len_of(e.b))
        $display("[TB] FAIL cmd_out cyc %0d: got v=%b t=%0d ba=%0d ra=%h ca=%h id=%h len=%h, want v=1 t=%0d ba=%0d ra=%h ca=%h id=%h len=%h",
                 cyc, cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len,
                 e.t, e.b, ra_of(e.b), ca_of(e.b), id_of(e.b), len_of(e.b));
      else passes++;
      last_ba = 4'(e.b); last_ra = ra_of(e.b); last_ca = ca_of(e.b);
      last_id = id_of(e.b); last_len = len_of(e.b);
    end else begin
      checks++;
      if (cmd_valid !== 1'b0 || cmd_type !== T_NOP || cmd_ba !== last_ba || cmd_ra !== last_ra ||
          cmd_ca !== last_ca || cmd_id !== last_id || cmd_len !== last_len)
        $display("[TB] FAIL cmd_idle cyc %0d: got v=%b t=%0d ba=%0d ra=%h, want v=0 t=0 ba=%0d ra=%h (fields held)",
                 cyc, cmd_valid, cmd_type, cmd_ba, cmd_ra, last_ba, last_ra);
      else passes++;
    end
  end

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0; t_faw_m1 = '0;
    sb.delete();
    act_req[3] = 1'b1;
    #2;
    checks++;
    if (gnt_all !== '0) $display("[TB] FAIL reset_grants: got %h want 0", gnt_all);
    else passes++;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_type !== T_NOP || cmd_ba !== 4'd0 || cmd_ra !== 16'd0)
      $display("[TB] FAIL reset_cmd: got v=%b t=%0d ba=%0d ra=%h want 0", cmd_valid, cmd_type, cmd_ba, cmd_ra);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] et;
      int eb;
      et = (k == 0) ? T_ACT : T_NOP;
      eb = 3;
      @(negedge clk);
      checks++;
      if (gnt_all !== gvec(et, eb)) $display("[TB] FAIL reset_first_grant k=%0d: got %h want %h", k, gnt_all, gvec(et, eb));
      else passes++;
      if (k == 1) begin
        checks++;
        if (cmd_type !== T_ACT || cmd_ba !== 4'd3 || cmd_ra !== 16'h1A2B)
          $display("[TB] FAIL reset_first_cmd: got t=%0d ba=%0d ra=%h want t=1 ba=3 ra=1a2b", cmd_type, cmd_ba, cmd_ra);
        else passes++;
      end
      if (et != T_NOP) push_cmd(et, eb);
      @(posedge clk); #1;
      if (et != T_NOP) drop_req(et, eb);
    end
  endtask

  task automatic test_trrd();
    do_reset(3, 0, 0, 0, 0);
    act_req[0] = 1'b1;
    act_req[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic [2:0] et;
      int eb;
      et = T_NOP; eb = 0;
      if (k == 0) begin et = T_ACT; eb = 0; end
      if (k == 4) begin et = T_ACT; eb = 1; end
      @(negedge clk);
      checks++;
      if (gnt_all !== gvec(et, eb)) $display("[TB] FAIL trrd k=%0d: got %h want %h", k, gnt_all, gvec(et, eb));
      else passes++;
      if (et != T_NOP) push_cmd(et, eb);
      @(posedge clk); #1;
      if (et != T_NOP) drop_req(et, eb);
    end
  endtask

  task automatic test_turnaround();
    do_reset(0, 1, 5, 2, 0);
    wr_req[2] = 1'b1;
    rd_req[5] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      logic [2:0] et;
      int eb;
      et = T_NOP; eb = 0;
      if (k == 0) begin et = T_WR; eb = 2; end
      if (k == 6) begin et = T_RD; eb = 5; end
      if (k == 9) begin et = T_WR; eb = 2; end
      @(negedge clk);
      checks++;
      if (gnt_all !== gvec(et, eb)) $display("[TB] FAIL turnaround k=%0d: got %h want %h", k, gnt_all, gvec(et, eb));
      else passes++;
      if (et != T_NOP) push_cmd(et, eb);
      @(posedge clk); #1;
      if (et != T_NOP) drop_req(et, eb);
      if (k == 6) wr_req[2] = 1'b1;
    end
  endtask

  task automatic test_priority();
    do_reset(3, 0, 0, 0, 0);
    ref_req[7] = 1'b1;
    rd_req[1]  = 1'b1;
    act_req[4] = 1'b1;
    pre_req[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [2:0] et;
      int eb;
      et = T_NOP; eb = 0;
      case (k)
        0: begin et = T_REF; eb = 7; end
        1: begin et = T_RD;  eb = 1; end
        2: begin et = T_ACT; eb = 4; end
        3: begin et = T_PRE; eb = 0; end
        default: ;
      endcase
      @(negedge clk);
      checks++;
      if (gnt_all !== gvec(et, eb)) $display("[TB] FAIL priority k=%0d: got %h want %h", k, gnt_all, gvec(et, eb));
      else passes++;
      if (et != T_NOP) push_cmd(et, eb);
      @(posedge clk); #1;
      if (et != T_NOP) drop_req(et, eb);
    end
  endtask

  task automatic test_act_sweep();
    do_reset(3, 0, 0, 0, 0);
    act_req = '1;
    for (int k = 0; k < 63; k++) begin
      logic [2:0] et;
      int eb;
      et = (k % 4 == 0) ? T_ACT : T_NOP;
      eb = k / 4;
      @(negedge clk);
      checks++;
      if (gnt_all !== gvec(et, eb)) $display("[TB] FAIL act_sweep k=%0d: got %h want %h", k, gnt_all, gvec(et, eb));
      else passes++;
      if (et != T_NOP) push_cmd(et, eb);
      @(posedge clk); #1;
      if (et != T_NOP) drop_req(et, eb);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(0, 0, 0, 0, 0);
    rd_req[9]   = 1'b1;
    wr_req[10]  = 1'b1;
    act_req[11] = 1'b1;
    act_req[2]  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [2:0] et;
      int eb;
      et = T_NOP; eb = 0;
      case (k)
        0: begin et = T_RD;  eb = 9;  end
        1: begin et = T_WR;  eb = 10; end
        2: begin et = T_ACT; eb = 11; end
        3: begin et = T_ACT; eb = 2;  end
        default: ;
      endcase
      @(negedge clk);
      checks++;
      if (gnt_all !== gvec(et, eb)) $display("[TB] FAIL back_to_back k=%0d: got %h want %h", k, gnt_all, gvec(et, eb));
      else passes++;
      if (et != T_NOP) push_cmd(et, eb);
      @(posedge clk); #1;
      if (et != T_NOP) drop_req(et, eb);
    end
  endtask

  task automatic test_reset_midop();
    do_reset(0, 0, 0, 2, 0);
    rd_req[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_all !== gvec(T_RD, 1)) $display("[TB] FAIL midop_rd: got %h want %h", gnt_all, gvec(T_RD, 1));
    else passes++;
    push_cmd(T_RD, 1);
    @(posedge clk); #1;
    rd_req[1] = 1'b0;
    wr_req[6] = 1'b1;
    #1;
    checks++;
    if (cmd_valid !== 1'b1 || gnt_all !== '0)
      $display("[TB] FAIL midop_pre_reset: got v=%b gnt=%h want v=1 gnt=0", cmd_valid, gnt_all);
    else passes++;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_type !== T_NOP || cmd_ba !== 4'd0 || cmd_ra !== 16'd0 || gnt_all !== '0)
      $display("[TB] FAIL midop_async_clear: got v=%b t=%0d ba=%0d ra=%h gnt=%h want all 0",
               cmd_valid, cmd_type, cmd_ba, cmd_ra, gnt_all);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] et;
      int eb;
      et = (k == 0) ? T_WR : T_NOP;
      eb = 6;
      @(negedge clk);
      checks++;
      if (gnt_all !== gvec(et, eb)) $display("[TB] FAIL midop_after k=%0d: got %h want %h", k, gnt_all, gvec(et, eb));
      else passes++;
      if (et != T_NOP) push_cmd(et, eb);
      @(posedge clk); #1;
      if (et != T_NOP) drop_req(et, eb);
    end
  endtask

`ifdef SAL_SCHED_FAW_EN
  task automatic test_faw();
    do_reset(0, 0, 0, 0, 15);
    act_req[4:0] = 5'h1F;
    for (int k = 0; k < 19; k++) begin
      logic [2:0] et;
      int eb;
      et = T_NOP; eb = 0;
      if (k < 4)   begin et = T_ACT; eb = k; end
      if (k == 16) begin et = T_ACT; eb = 4; end
      @(negedge clk);
      checks++;
      if (gnt_all !== gvec(et, eb)) $display("[TB] FAIL faw k=%0d: got %h want %h", k, gnt_all, gvec(et, eb));
      else passes++;
      if (et != T_NOP) push_cmd(et, eb);
      @(posedge clk); #1;
      if (et != T_NOP) drop_req(et, eb);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0; t_faw_m1 = '0;
    for (int b = 0; b < N; b++) begin
      ra_in[b*16 +: 16] = ra_of(b);
      ca_in[b*10 +: 10] = ca_of(b);
      id_in[b*4 +: 4]   = id_of(b);
      len_in[b*4 +: 4]  = len_of(b);
    end
    test_reset();
    test_trrd();
    test_turnaround();
    test_priority();
    test_act_sweep();
    test_back_to_back();
    test_reset_midop();
`ifdef SAL_SCHED_FAW_EN
    test_faw();
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) $display("[TB] FAIL sb_drain: got %0d pending want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
